// File: rtl/uart_cmd_host.sv
// uart_cmd_host: host-side command initiator for the UART command protocol.
// Serialises one request into a frame byte stream, then gathers the response
// bytes (LSB first) and returns them with a timeout error flag.
module uart_cmd_host #(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TMR_WIDTH   = 13
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_cmd,
  input  logic [3:0]                req_addr,
  input  logic [DATA_WIDTH-1:0]     req_opa,
  input  logic [DATA_WIDTH-1:0]     req_opb,
  input  logic [3:0]                req_fun,
  output logic [DATA_WIDTH-1:0]     tx_byte,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [DATA_WIDTH-1:0]     rx_byte,
  input  logic                      rx_valid,
  output logic                      rsp_valid,
  output logic [2*DATA_WIDTH-1:0]   rsp_data,
  output logic                      rsp_err
);

  localparam logic [1:0] CMD_WR  = 2'd0;
  localparam logic [1:0] CMD_RD  = 2'd1;
  localparam logic [1:0] CMD_ALU = 2'd2;
  localparam logic [1:0] CMD_NOP = 2'd3;

  // Timer value one below the abort threshold: when the incremented timer
  // would reach TIMEOUT_CYC-1 with no byte arriving, the command aborts.
  localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 idx_q, idx_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [TMR_WIDTH-1:0]       tmr_q, tmr_d;
  logic [2*DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                       rsp_err_q, rsp_err_d;
  logic [2*DATA_WIDTH-1:0]    buf_q, buf_d;
  logic                       ld_req;

  logic [1:0]                 cmd_q;
  logic [3:0]                 addr_q;
  logic [DATA_WIDTH-1:0]      opa_q;
  logic [DATA_WIDTH-1:0]      opb_q;
  logic [3:0]                 fun_q;

  // Index of the final frame byte for each command.
  function automatic logic [1:0] last_idx(input logic [1:0] cmd);
    case (cmd)
      CMD_WR:  last_idx = 2'd2;
      CMD_RD:  last_idx = 2'd1;
      CMD_ALU: last_idx = 2'd3;
      default: last_idx = 2'd1;
    endcase
  endfunction

  // Number of response bytes expected for each command.
  function automatic logic [1:0] rsp_cnt(input logic [1:0] cmd);
    case (cmd)
      CMD_WR:  rsp_cnt = 2'd0;
      CMD_RD:  rsp_cnt = 2'd1;
      default: rsp_cnt = 2'd2;
    endcase
  endfunction

  // Frame byte at position idx, built from the latched request fields.
  function automatic logic [DATA_WIDTH-1:0] frame_byte(
    input logic [1:0]            cmd,
    input logic [1:0]            idx,
    input logic [3:0]            addr,
    input logic [DATA_WIDTH-1:0] opa,
    input logic [DATA_WIDTH-1:0] opb,
    input logic [3:0]            fun
  );
    frame_byte = '0;
    case (cmd)
      CMD_WR: begin
        case (idx)
          2'd0:    frame_byte = DATA_WIDTH'(8'hAA);
          2'd1:    frame_byte = DATA_WIDTH'(addr);
          default: frame_byte = opa;
        endcase
      end
      CMD_RD: begin
        if (idx == 2'd0) frame_byte = DATA_WIDTH'(8'hBB);
        else             frame_byte = DATA_WIDTH'(addr);
      end
      CMD_ALU: begin
        case (idx)
          2'd0:    frame_byte = DATA_WIDTH'(8'hCC);
          2'd1:    frame_byte = opa;
          2'd2:    frame_byte = opb;
          default: frame_byte = DATA_WIDTH'(fun);
        endcase
      end
      default: begin
        if (idx == 2'd0) frame_byte = DATA_WIDTH'(8'hDD);
        else             frame_byte = DATA_WIDTH'(fun);
      end
    endcase
  endfunction

  // Next-state, counters, response capture and handshake outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    buf_d      = buf_q;
    ld_req     = 1'b0;
    req_ready  = 1'b0;
    tx_valid   = 1'b0;
    tx_byte    = '0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ld_req  = 1'b1;
          buf_d   = '0;
          idx_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_byte  = frame_byte(cmd_q, idx_q, addr_q, opa_q, opb_q, fun_q);
        if (tx_ready) begin
          if (idx_q == last_idx(cmd_q)) begin
            idx_d = 2'd0;
            if (cmd_q == CMD_WR) begin
              rsp_data_d = '0;
              rsp_err_d  = 1'b0;
              state_d    = DONE;
            end else begin
              tmr_d   = '0;
              cnt_d   = 2'd0;
              state_d = WAIT_RSP;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WAIT_RSP: begin
        tmr_d = tmr_q + TMR_WIDTH'(1);
        if (rx_valid) begin
          // A byte arriving on the expiry cycle still counts and restarts the timer.
          if (cnt_q == 2'd0) buf_d[DATA_WIDTH-1:0]            = rx_byte;
          else               buf_d[2*DATA_WIDTH-1:DATA_WIDTH] = rx_byte;
          tmr_d = '0;
          cnt_d = cnt_q + 2'd1;
          if (cnt_d == rsp_cnt(cmd_q)) begin
            rsp_data_d = buf_d;
            rsp_err_d  = 1'b0;
            state_d    = DONE;
          end
        end else if (tmr_q == TMR_LAST) begin
          rsp_data_d = buf_q;
          rsp_err_d  = 1'b1;
          state_d    = DONE;
        end
      end
      default: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // Control state and response registers, cleared by the asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Request fields latched on acceptance; response assembly buffer.
  always_ff @(posedge CLK) begin
    if (ld_req) begin
      cmd_q  <= req_cmd;
      addr_q <= req_addr;
      opa_q  <= req_opa;
      opb_q  <= req_opb;
      fun_q  <= req_fun;
    end
    buf_q <= buf_d;
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host (timeout shortened to 64 cycles).
module tb_uart_cmd_host;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [3:0]  req_addr;
  logic [7:0]  req_opa;
  logic [7:0]  req_opb;
  logic [3:0]  req_fun;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int n_pass  = 0;
  int n_total = 0;
  int n;
  logic [7:0] alu_exp [4] = '{8'hCC, 8'h12, 8'h34, 8'h00};

  uart_cmd_host #(.DATA_WIDTH(8), .TIMEOUT_CYC(64), .TMR_WIDTH(7)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_opa(req_opa), .req_opb(req_opb), .req_fun(req_fun),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic issue(input logic [1:0] c, input logic [3:0] a,
                       input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
    req_valid = 1'b1; req_cmd = c; req_addr = a; req_opa = oa; req_opb = ob; req_fun = f;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] b);
    chk({tag, "_valid"}, tx_valid, 1);
    chk(tag, tx_byte, b);
    tick();
  endtask

  task automatic rx(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_opa = '0;
    req_opb = '0; req_fun = '0; tx_ready = 1'b0; rx_byte = '0; rx_valid = 1'b0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    RST = 1'b0;
    tick();

    // REG_WR addr 5, data 0x3C, transmitter always ready
    tx_ready = 1'b1;
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
    chk("wr_ready_drop", req_ready, 0);
    expect_tx("wr_b0", 8'hAA);
    expect_tx("wr_b1", 8'h05);
    expect_tx("wr_b2", 8'h3C);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_data", rsp_data, 16'h0000);
    chk("wr_rsp_err", rsp_err, 0);
    tick();
    chk("wr_rsp_pulse", rsp_valid, 0);
    chk("wr_idle_ready", req_ready, 1);

    // REG_RD addr 2, one response byte after ~20 cycles
    issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
    expect_tx("rd_b0", 8'hBB);
    expect_tx("rd_b1", 8'h02);
    chk("rd_wait_txv", tx_valid, 0);
    repeat (19) tick();
    chk("rd_no_early_rsp", rsp_valid, 0);
    rx(8'h81);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, 16'h0081);
    chk("rd_rsp_err", rsp_err, 0);
    tick();

    // ALU_OP with tx_ready one cycle on, two off
    issue(2'd2, 4'h0, 8'h12, 8'h34, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tx_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
        chk("alu_hold_valid", tx_valid, 1);
        chk("alu_hold_byte", tx_byte, alu_exp[i]);
        tick();
      end
      chk("alu_accept_byte", tx_byte, alu_exp[i]);
      tx_ready = 1'b1;
      tick();
    end
    chk("alu_wait_txv", tx_valid, 0);
    rx(8'h46);
    chk("alu_half_rsp", rsp_valid, 0);
    tick(); tick();
    rx(8'h00);
    chk("alu_rsp_valid", rsp_valid, 1);
    chk("alu_rsp_data", rsp_data, 16'h0046);
    chk("alu_rsp_err", rsp_err, 0);
    tick();
    chk("alu_rsp_pulse", rsp_valid, 0);
    chk("alu_rsp_hold", rsp_data, 16'h0046);

    // ALU_NOP fun 2, one byte then silence until timeout
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h2);
    expect_tx("nop_b0", 8'hDD);
    expect_tx("nop_b1", 8'h02);
    tick();
    rx(8'h10);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("nop_timeout_cycles", n, 64);
    chk("nop_rsp_err", rsp_err, 1);
    chk("nop_rsp_data", rsp_data, 16'h0010);
    tick();

    // Overlap: request held during WAIT_RSP, stray byte in IDLE
    issue(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
    expect_tx("ovl_b0", 8'hBB);
    expect_tx("ovl_b1", 8'h03);
    req_valid = 1'b1; req_cmd = 2'd0; req_addr = 4'h7; req_opa = 8'h55;
    tick();
    chk("ovl_ready_wait", req_ready, 0);
    tick(); tick();
    rx(8'h22);
    chk("ovl_rsp_valid", rsp_valid, 1);
    chk("ovl_rsp_data", rsp_data, 16'h0022);
    chk("ovl_ready_done", req_ready, 0);
    req_valid = 1'b0;
    tick();
    chk("ovl_idle_ready", req_ready, 1);
    chk("ovl_not_accepted", tx_valid, 0);
    rx(8'hEE);
    chk("stray_ready", req_ready, 1);
    chk("stray_txv", tx_valid, 0);
    chk("stray_rsp", rsp_valid, 0);
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h7);
    expect_tx("nop2_b0", 8'hDD);
    expect_tx("nop2_b1", 8'h07);
    rx(8'h3C);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("nop2_timeout_cycles", n, 64);
    chk("nop2_rsp_err", rsp_err, 1);
    chk("nop2_rsp_data", rsp_data, 16'h003C);
    tick();

    // Reset while ALU_OP byte 2 is pending
    issue(2'd2, 4'h0, 8'hAB, 8'hCD, 4'h5);
    expect_tx("rst_alu_b0", 8'hCC);
    expect_tx("rst_alu_b1", 8'hAB);
    tx_ready = 1'b0;
    chk("rst_alu_b2", tx_byte, 8'hCD);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_tx_byte", tx_byte, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_rsp_err", rsp_err, 0);
    tick();
    RST = 1'b0;
    tx_ready = 1'b1;
    tick();
    chk("post_rst_idle", tx_valid, 0);
    issue(2'd1, 4'h9, 8'h00, 8'h00, 4'h0);
    expect_tx("post_rd_b0", 8'hBB);
    expect_tx("post_rd_b1", 8'h09);
    rx(8'h5A);
    chk("post_rd_valid", rsp_valid, 1);
    chk("post_rd_data", rsp_data, 16'h005A);
    chk("post_rd_err", rsp_err, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_host.md
Name: uart_cmd_host

Overview:
- Host-side command initiator for the system's UART command protocol. It is the far end of the system controller.
- Accepts one command request at a time and serialises it into the frame byte stream for a UART transmitter.
- Collects the response bytes from a UART receiver and returns the assembled result with an error flag.
- Used in the top-level testbench and in the FPGA host bridge to drive register-file and ALU traffic.

Parameters:
- DATA_WIDTH, 8, byte width of the UART payload and operands.
- TIMEOUT_CYC, 4096, CLK cycles allowed between response bytes before the command aborts.
- TMR_WIDTH, 13, width of the timeout counter; must satisfy 2^TMR_WIDTH > TIMEOUT_CYC.

Ports:
- CLK  input  1  block clock.
- RST  input  1  reset: asynchronous, active-high.
- req_valid  input  1  command request present.
- req_ready  output  1  block can accept a request.
- req_cmd  input  2  0=REG_WR, 1=REG_RD, 2=ALU_OP (with operands), 3=ALU_NOP (no operands).
- req_addr  input  4  register-file address.
- req_opa  input  DATA_WIDTH  write data (REG_WR) or operand A.
- req_opb  input  DATA_WIDTH  operand B.
- req_fun  input  4  ALU function code.
- tx_byte  output  DATA_WIDTH  byte offered to the UART transmitter.
- tx_valid  output  1  tx_byte is valid.
- tx_ready  input  1  transmitter accepts tx_byte this cycle.
- rx_byte  input  DATA_WIDTH  byte from the UART receiver.
- rx_valid  input  1  single-cycle strobe: rx_byte is valid.
- rsp_valid  output  1  single-cycle pulse: command complete.
- rsp_data  output  2*DATA_WIDTH  result: {MSB, LSB}.
- rsp_err  output  1  qualifies rsp_valid: response timed out.

Behaviour:
- Reset values: req_ready=1, tx_valid=0, tx_byte=0, rsp_valid=0, rsp_data=0, rsp_err=0; FSM=IDLE; counters=0.
- Frames, in byte order:
  - REG_WR: 0xAA, {4'b0,addr}, opa.
  - REG_RD: 0xBB, {4'b0,addr}.
  - ALU_OP: 0xCC, opa, opb, {4'b0,fun}.
  - ALU_NOP: 0xDD, {4'b0,fun}.
- Expected response bytes: REG_WR 0, REG_RD 1, ALU_OP 2, ALU_NOP 2. ALU responses arrive LSB first.
- FSM IDLE:
  - req_ready=1.
  - A request is accepted on the edge where req_valid&&req_ready. All request fields are latched at that edge.
  - Next state SEND with byte index 0. req_ready drops in the next cycle.
- FSM SEND:
  - tx_valid=1; tx_byte = frame[idx], driven combinationally from the latched fields and idx.
  - tx_byte and tx_valid stay stable until tx_ready. On tx_valid&&tx_ready, idx increments.
  - After the last byte is accepted: REG_WR goes to DONE; all other commands go to WAIT_RSP with the timer and byte count cleared.
  - tx_ready held low keeps the FSM in SEND indefinitely; there is no timeout while sending.
- FSM WAIT_RSP:
  - tx_valid=0. The timer increments every cycle.
  - On rx_valid: store rx_byte into byte slot cnt (slot 0 = LSB), cnt increments, timer clears.
  - When cnt reaches the expected count, go to DONE.
  - If the timer reaches TIMEOUT_CYC-1 with no rx_valid, set err=1 and go to DONE. Unfilled bytes read 0.
  - rx_valid in the same cycle as timer expiry: the byte wins and the timer clears.
- FSM DONE:
  - One cycle with rsp_valid=1, rsp_data and rsp_err valid; return to IDLE.
  - REG_WR: rsp_data=0, rsp_err=0.
  - rsp_data and rsp_err hold their values until the next DONE.
- rx_valid outside WAIT_RSP is ignored; extra bytes beyond the expected count are not captured.
- req_valid outside IDLE is ignored and not queued.
- Latency: accept-to-first tx_valid = 1 cycle. Final rx_valid to rsp_valid = 1 cycle.
- RST asserted mid-operation: immediate return to reset values. A partially sent frame is abandoned.

Test Plan:
- REG_WR addr=5 data=0x3C, tx_ready always 1 -> tx bytes 0xAA,0x05,0x3C on 3 consecutive cycles; rsp_valid 1 cycle after last byte; rsp_data=0, rsp_err=0.
- REG_RD addr=2, rx_byte 0x81 after 20 cycles -> tx 0xBB,0x02; rsp_valid one cycle after rx_valid; rsp_data=0x0081, rsp_err=0.
- ALU_OP A=0x12 B=0x34 fun=0, tx_ready toggling 1 cycle on / 2 off, rx 0x46 then 0x00 -> tx 0xCC,0x12,0x34,0x00 each held stable until accepted; rsp_data=0x0046.
- ALU_NOP fun=2, TIMEOUT_CYC=64, only rx 0x10 then silence -> rsp_valid exactly 64 cycles after that byte; rsp_err=1, rsp_data=0x0010.
- Overlap: req_valid during WAIT_RSP plus rx_valid arriving in IDLE -> second request not accepted; stray byte not stored; req_ready=0 until after DONE.
- RST pulse during SEND of ALU_OP byte 2 -> all outputs at reset values immediately; next REG_RD runs a fresh frame starting with 0xBB.
